// File: rtl/easy_fifo_pack_pkg.sv
// -----------------------------------------------------------------------------
// easy_fifo_pkg
// Shared definitions for the easy_fifo_pack word packer.
//   clog2_min1   : index width helper that never returns 0
//   lane_cnt_t   : argument type of the keep-mask generator helper
//   keep_bit     : keep-mask generator, one lane at a time
//   DEFAULT_TIMEOUT : default idle-flush threshold
// -----------------------------------------------------------------------------
package easy_fifo_pkg;

    localparam int DEFAULT_TIMEOUT = 64;

    typedef int unsigned lane_cnt_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Lane 'lane' is kept when it lies below the fill count.
    function automatic logic keep_bit(input lane_cnt_t lane, input lane_cnt_t fill);
        return (lane < fill);
    endfunction

endpackage

// File: rtl/easy_fifo_pack_if.sv
// -----------------------------------------------------------------------------
// easy_fifo_pack_if
// Bundles the FIFO read port, the flush request and the packed-beat
// valid/ready output of easy_fifo_pack.
//   master : the packer (pops the FIFO, drives the beat)
//   slave  : the environment (FIFO + downstream consumer)
// -----------------------------------------------------------------------------
interface easy_fifo_pack_if #(
    parameter int DWIDTH = 32,
    parameter int RATIO  = 4
);
    logic [DWIDTH-1:0]       fifo_rd_data;
    logic                    fifo_rd_empty;
    logic                    fifo_rd_en;
    logic                    flush;
    logic [DWIDTH*RATIO-1:0] m_data;
    logic [RATIO-1:0]        m_keep;
    logic                    m_valid;
    logic                    m_ready;

    modport master (
        input  fifo_rd_data, fifo_rd_empty, flush, m_ready,
        output fifo_rd_en, m_data, m_keep, m_valid
    );

    modport slave (
        output fifo_rd_data, fifo_rd_empty, flush, m_ready,
        input  fifo_rd_en, m_data, m_keep, m_valid
    );
endinterface

// File: rtl/easy_fifo_pack_acc.sv
// -----------------------------------------------------------------------------
// easy_fifo_pack_acc
// Lane accumulator: RATIO lane registers, fill index and keep generation.
//   clk, rst   : clock, synchronous active-low reset
//   pop_i      : a FIFO word is popped this cycle
//   load_i     : a beat (full or partial) is moved to the output this cycle
//   rd_data_i  : popped word
//   last_o     : fill index sits on the final lane
//   empty_o    : fill index is 0
//   keep_o     : keep mask for the fill count including a same-cycle pop
//   lanes_o    : lane contents including a same-cycle pop (lane 0 = LSBs)
// -----------------------------------------------------------------------------
module easy_fifo_pack_acc
    import easy_fifo_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int RATIO  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pop_i,
    input  logic                    load_i,
    input  logic [DWIDTH-1:0]       rd_data_i,
    output logic                    last_o,
    output logic                    empty_o,
    output logic [RATIO-1:0]        keep_o,
    output logic [DWIDTH*RATIO-1:0] lanes_o
);
    localparam int IW = clog2_min1(RATIO);
    localparam int CW = clog2_min1(RATIO + 1);

    logic [DWIDTH-1:0] lanes_q    [RATIO];
    logic [DWIDTH-1:0] lanes_view [RATIO];
    logic [DWIDTH-1:0] lanes_d    [RATIO];
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     fill;

    assign last_o  = (idx_q == IW'(RATIO - 1));
    assign empty_o = (idx_q == '0);
    assign fill    = CW'(idx_q) + CW'(pop_i);

    // The view folds the same-cycle pop in so a completing or flushed beat
    // carries the word arriving this cycle.
    always_comb begin
        for (int i = 0; i < RATIO; i++) begin
            lanes_view[i] = lanes_q[i];
            if (pop_i && (idx_q == IW'(i))) begin
                lanes_view[i] = rd_data_i;
            end
            lanes_o[i*DWIDTH +: DWIDTH] = lanes_view[i];
            keep_o[i] = keep_bit(lane_cnt_t'(i), lane_cnt_t'(fill));
        end
    end

    // Lanes are zeroed whenever a beat leaves so unused lanes of a later
    // partial beat read as 0.
    always_comb begin
        idx_d = idx_q;
        for (int i = 0; i < RATIO; i++) begin
            lanes_d[i] = lanes_view[i];
        end
        if (load_i) begin
            idx_d = '0;
            for (int i = 0; i < RATIO; i++) begin
                lanes_d[i] = '0;
            end
        end else if (pop_i) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q <= '0;
            for (int i = 0; i < RATIO; i++) begin
                lanes_q[i] <= '0;
            end
        end else begin
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
        end
    end

endmodule

// File: rtl/easy_fifo_pack.sv
// -----------------------------------------------------------------------------
// easy_fifo_pack
// Pops narrow words from a first-word-fall-through FIFO and packs RATIO of
// them (little-endian, first word in lane 0) into one wide valid/ready beat
// with a per-lane keep mask. A flush request emits a partially filled beat.
//   clk  : clock
//   rst  : synchronous active-low reset
//   bus  : easy_fifo_pack_if.master
//            fifo_rd_data/fifo_rd_empty/fifo_rd_en : FIFO read port
//            flush                                 : partial-beat request
//            m_data/m_keep/m_valid/m_ready         : packed beat output
// Optional build macro EASY_FIFO_PACK_TIMEOUT_EN: adds an idle counter that
// raises a flush after TIMEOUT cycles with a partly filled accumulator and no
// pop. Without it TIMEOUT is only range-checked.
// -----------------------------------------------------------------------------
module easy_fifo_pack
    import easy_fifo_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    easy_fifo_pack_if.master  bus
);
    localparam int BW = DWIDTH * RATIO;

    if (RATIO < 2 || TIMEOUT < 1) begin : g_bad_param
        $error("easy_fifo_pack: RATIO must be >= 2 and TIMEOUT >= 1");
    end

    logic             acc_last, acc_empty;
    logic [RATIO-1:0] keep_nxt;
    logic [BW-1:0]    lanes_nxt;
    logic             out_free, rd_en, pop;
    logic             full_done, load_partial, beat_load, timeout_hit;
    logic             flush_pend_q, flush_pend_d;
    logic             m_valid_q, m_valid_d;
    logic [BW-1:0]    m_data_q, m_data_d;
    logic [RATIO-1:0] m_keep_q, m_keep_d;

    easy_fifo_pack_acc #(
        .DWIDTH (DWIDTH),
        .RATIO  (RATIO)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .pop_i     (pop),
        .load_i    (beat_load),
        .rd_data_i (bus.fifo_rd_data),
        .last_o    (acc_last),
        .empty_o   (acc_empty),
        .keep_o    (keep_nxt),
        .lanes_o   (lanes_nxt)
    );

    // Only the final lane needs a free output register; earlier lanes
    // keep filling while a beat waits downstream.
    assign out_free     = ~m_valid_q | bus.m_ready;
    assign rd_en        = rst & (~acc_last | out_free);
    assign pop          = rd_en & ~bus.fifo_rd_empty;
    assign full_done    = pop & acc_last;
    assign load_partial = flush_pend_q & out_free & ~full_done;
    assign beat_load    = full_done | load_partial;

`ifdef EASY_FIFO_PACK_TIMEOUT_EN
    localparam int TW = clog2_min1(TIMEOUT + 1);

    logic [TW-1:0] idle_q, idle_d;

    // Saturates at TIMEOUT so a waiting flush is raised only once.
    always_comb begin
        idle_d      = idle_q;
        timeout_hit = 1'b0;
        if (pop || beat_load || acc_empty) begin
            idle_d = '0;
        end else if (idle_q != TW'(TIMEOUT)) begin
            idle_d      = idle_q + 1'b1;
            timeout_hit = (idle_q == TW'(TIMEOUT - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // A flush is only remembered when there is something to flush; any beat
    // load empties the accumulator, so it also retires a pending flush.
    always_comb begin
        flush_pend_d = flush_pend_q;
        if (beat_load) begin
            flush_pend_d = 1'b0;
        end else if ((bus.flush | timeout_hit) & (pop | ~acc_empty)) begin
            flush_pend_d = 1'b1;
        end
    end

    // keep_nxt is all ones on a full completion, so both beat kinds share
    // one load path.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        if (beat_load) begin
            m_valid_d = 1'b1;
            m_data_d  = lanes_nxt;
            m_keep_d  = keep_nxt;
        end else if (bus.m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            flush_pend_q <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
        end else begin
            flush_pend_q <= flush_pend_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = m_data_q;
    assign bus.m_keep     = m_keep_q;

endmodule

// File: tb/tb_easy_fifo_pack.sv
// -----------------------------------------------------------------------------
// tb_easy_fifo_pack
// Directed bench for easy_fifo_pack (DWIDTH=8, RATIO=4, TIMEOUT=5) with a
// FIFO model and a scoreboard of expected beats checked by a monitor.
// -----------------------------------------------------------------------------
module tb_easy_fifo_pack;
    localparam int DW = 8;
    localparam int R  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    easy_fifo_pack_if #(.DWIDTH(DW), .RATIO(R)) bus();

    easy_fifo_pack #(
        .DWIDTH  (DW),
        .RATIO   (R),
        .TIMEOUT (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] fifo_q[$];
    bit         pop_flag = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;

    // FIFO model: head presented at negedge, pop taken on the DUT's edge.
    always @(negedge clk) begin
        if (fifo_q.size() > 0) begin
            bus.fifo_rd_data  = fifo_q[0];
            bus.fifo_rd_empty = 1'b0;
        end else begin
            bus.fifo_rd_data  = '0;
            bus.fifo_rd_empty = 1'b1;
        end
        pop_flag = rst && bus.fifo_rd_en && (fifo_q.size() > 0);
    end

    always @(posedge clk) begin
        if (pop_flag) begin
            void'(fifo_q.pop_front());
        end
    end

    // Monitor: every accepted beat is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst && bus.m_valid && bus.m_ready) begin
            beat_t e;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_beat: got data=%h keep=%b, required no beat",
                         bus.m_data, bus.m_keep);
            end else begin
                e = exp_q.pop_front();
                if (bus.m_data !== e.d || bus.m_keep !== e.k) begin
                    n_err++;
                    $display("FAIL beat: got data=%h keep=%b, required data=%h keep=%b",
                             bus.m_data, bus.m_keep, e.d, e.k);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic push(input logic [7:0] w);
        fifo_q.push_back(w);
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [3:0] k);
        beat_t b;
        b.d = d;
        b.k = k;
        exp_q.push_back(b);
    endtask

    task automatic drain(input string name, input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && c < budget) begin
            @(posedge clk);
            c++;
        end
        check(name, 32'(exp_q.size() + fifo_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.m_valid && cyc < budget);
        if (!bus.m_valid) cyc = -1;
    endtask

    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.m_valid) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int cnt;
        bus.fifo_rd_data  = '0;
        bus.fifo_rd_empty = 1'b1;
        bus.flush         = 1'b0;
        bus.m_ready       = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid",    32'(bus.m_valid),    32'd0);
        check("rst_m_keep",     32'(bus.m_keep),     32'd0);
        check("rst_m_data",     bus.m_data,          32'd0);
        check("rst_fifo_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // One full beat
        bus.m_ready = 1'b1;
        expect_beat(32'h04030201, 4'b1111);
        for (int i = 1; i <= 4; i++) push(8'(i));
        wait_valid(20, cyc);
        check("t1_latency", 32'(cyc), 32'd5);
        count_valid(6, cnt);
        check("t1_valid_extra_cycles", 32'(cnt), 32'd0);
        drain("t1_drain", 50);

        // Back-pressure: stall on the last lane, beat held
        bus.m_ready = 1'b0;
        expect_beat(32'h04030201, 4'b1111);
        expect_beat(32'h08070605, 4'b1111);
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_valid(20, cyc);
        check("t2_first_valid", 32'(cyc), 32'd5);
        repeat (5) @(negedge clk);
        check("t2_stall_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("t2_held_data",   bus.m_data,          32'h04030201);
        check("t2_held_valid",  32'(bus.m_valid),    32'd1);
        check("t2_fifo_left",   32'(fifo_q.size()),  32'd1);
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        drain("t2_drain", 50);

        // Partial beat via flush, then a fresh full beat from lane 0
        expect_beat(32'h0000BBAA, 4'b0011);
        push(8'hAA);
        push(8'hBB);
        repeat (4) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        drain("t3_partial_drain", 50);
        expect_beat(32'h44332211, 4'b1111);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        drain("t3_full_drain", 50);

        // Flush with empty accumulator: no beat
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        count_valid(10, cnt);
        check("t4_no_empty_beat", 32'(cnt), 32'd0);
        @(posedge clk); #1;

        // Flush coinciding with the completing pop: exactly one full beat
        expect_beat(32'hC4C3C2C1, 4'b1111);
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        repeat (3) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        count_valid(10, cnt);
        check("t4_single_beat", 32'(cnt), 32'd1);
        drain("t4_drain", 50);

        // Reset with a held beat and idx=2; held beat is discarded
        bus.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'h51 + 8'(i));
        repeat (10) @(posedge clk);
        #1;
        check("t5_pre_valid",     32'(bus.m_valid),   32'd1);
        check("t5_pre_fifo_left", 32'(fifo_q.size()), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_rst_m_valid",    32'(bus.m_valid),    32'd0);
        check("t5_rst_m_keep",     32'(bus.m_keep),     32'd0);
        check("t5_rst_m_data",     bus.m_data,          32'd0);
        check("t5_rst_fifo_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.m_ready = 1'b1;
        expect_beat(32'h64636261, 4'b1111);
        push(8'h61); push(8'h62); push(8'h63); push(8'h64);
        drain("t5_drain", 50);

`ifdef EASY_FIFO_PACK_TIMEOUT_EN
        // Idle timeout flushes a single word
        expect_beat(32'h0000003C, 4'b0001);
        push(8'h3C);
        wait_valid(30, cyc);
        check("t6_timeout_latency", 32'(cyc), 32'd8);
        drain("t6_drain", 50);
`endif

        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
